// File: rtl/fir_output_decimator.sv
// Integrate-and-dump decimator behind the 5-tap FIR: sums DECIM samples into one result.
// The result goes into a 2-entry output FIFO. Define FIR_DECIM_SAT_EN to saturate results instead of truncating them.
module fir_output_decimator #(
  parameter int IN_W  = 2,
  parameter int DECIM = 4,
  parameter int OUT_W = 4,
  parameter int PH_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  y_in,
  input  logic             y_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic [PH_W-1:0]  phase
);

  localparam int FULL_W = IN_W + $clog2(DECIM);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(DECIM - 1);

  logic [FULL_W-1:0] acc;
  logic [FULL_W-1:0] sum;
  logic [OUT_W-1:0]  result;
  logic [OUT_W-1:0]  slot0;
  logic [OUT_W-1:0]  slot1;
  logic [1:0]        count;
  logic              dump;
  logic              pop;

  assign sum  = acc + FULL_W'(y_in);
  assign dump = y_valid && (phase == LAST_PH);
  assign pop  = out_ready && (count != 2'd0);

  // Reduction to OUT_W happens only on the pushed value; the accumulator itself stays full precision.
  generate
    if (FULL_W > OUT_W) begin : g_narrow
`ifdef FIR_DECIM_SAT_EN
      assign result = (|sum[FULL_W-1:OUT_W]) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
      assign result = OUT_W'(sum);
`endif
    end else begin : g_wide
      assign result = OUT_W'(sum);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (y_valid) begin
      if (dump) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + PH_W'(1);
      end
    end
  end

  // slot0 is always the head; it is zeroed on the way to empty so out_data reads 0 when nothing is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      slot0   <= '0;
      slot1   <= '0;
      overrun <= 1'b0;
    end else begin
      case (count)
        2'd0: begin
          if (dump) begin
            slot0 <= result;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (dump && pop) begin
            slot0 <= result;
          end else if (dump) begin
            slot1 <= result;
            count <= 2'd2;
          end else if (pop) begin
            slot0 <= '0;
            count <= 2'd0;
          end
        end
        default: begin
          if (dump && pop) begin
            slot0 <= slot1;
            slot1 <= result;
          end else if (pop) begin
            slot0 <= slot1;
            count <= 2'd1;
          end
        end
      endcase

      if (dump && (count == 2'd2) && !pop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = slot0;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed table-driven bench for fir_output_decimator, plus a narrow OUT_W=3 instance
// whose expectations follow FIR_DECIM_SAT_EN.
module tb_fir_output_decimator;

  typedef struct {
    logic       rst;
    logic       yv;
    logic [1:0] y;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] eph;
    logic       eovr;
  } vec_t;

`ifdef FIR_DECIM_SAT_EN
  localparam int EXP_SUM12 = 7;
  localparam int EXP_SUM8  = 7;
`else
  localparam int EXP_SUM12 = 4;
  localparam int EXP_SUM8  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, y_valid, out_ready, ovr_clr, out_valid, overrun;
  logic [1:0] y_in, phase;
  logic [3:0] out_data;

  logic       n_rst, n_valid, n_rdy, n_clr, n_out_valid, n_ovr;
  logic [1:0] n_y, n_phase;
  logic [2:0] n_data;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  fir_output_decimator dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .ovr_clr(ovr_clr), .phase(phase)
  );

  fir_output_decimator #(.IN_W(2), .DECIM(4), .OUT_W(3), .PH_W(2)) dut_narrow (
    .clk(clk), .rst(n_rst), .y_in(n_y), .y_valid(n_valid),
    .out_data(n_data), .out_valid(n_out_valid), .out_ready(n_rdy),
    .overrun(n_ovr), .ovr_clr(n_clr), .phase(n_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic yv, input logic [1:0] y, input logic rdy,
                        input logic clr, input logic ev, input logic [3:0] ed,
                        input logic [1:0] eph, input logic eovr);
    vec_t v;
    v = '{rst: r, yv: yv, y: y, rdy: rdy, clr: clr, ev: ev, ed: ed, eph: eph, eovr: eovr};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic yv, input logic [1:0] y,
                               input logic rdy, input logic clr);
    rst = r; y_valid = yv; y_in = y; out_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input int ed,
                             input int eph, input logic eovr);
    check({tag, " out_valid"}, int'(out_valid), int'(ev));
    check({tag, " out_data"}, int'(out_data), ed);
    check({tag, " phase"}, int'(phase), eph);
    check({tag, " overrun"}, int'(overrun), int'(eovr));
  endtask

  task automatic applyNarrow(input logic v, input logic [1:0] y);
    n_valid = v; n_y = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; y_valid = 1'b0; y_in = 2'd0; out_ready = 1'b0; ovr_clr = 1'b0;
    n_rst = 1'b1; n_valid = 1'b0; n_y = 2'd0; n_rdy = 1'b1; n_clr = 1'b0;

    // rst yv y rdy clr | ev ed ph ovr
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 3, 1, 0, 0, 0, 1, 0);
    addVec(0, 1, 1, 1, 0, 0, 0, 2, 0);
    addVec(0, 1, 2, 1, 0, 0, 0, 3, 0);
    addVec(0, 1, 0, 1, 0, 1, 6, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      addVec(0, 1, 3, 1, 0, 0, 0, 2'(i + 1), 0);
      addVec(0, 0, 3, 1, 0, 0, 0, 2'(i + 1), 0);
    end
    addVec(0, 1, 3, 1, 0, 1, 12, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Overflow: two results held, third dropped, then drained and cleared
    addVec(0, 1, 1, 0, 0, 0, 0, 1, 0);
    addVec(0, 1, 1, 0, 0, 0, 0, 2, 0);
    addVec(0, 1, 1, 0, 0, 0, 0, 3, 0);
    addVec(0, 1, 1, 0, 0, 1, 4, 0, 0);
    for (int f = 0; f < 2; f++) begin
      addVec(0, 1, 1, 0, 0, 1, 4, 1, 0);
      addVec(0, 1, 1, 0, 0, 1, 4, 2, 0);
      addVec(0, 1, 1, 0, 0, 1, 4, 3, 0);
      addVec(0, 1, 1, 0, 0, 1, 4, 0, 1'(f));
    end
    addVec(0, 0, 0, 1, 0, 1, 4, 0, 1);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Full FIFO with a pop on the dump edge of the third frame
    addVec(0, 1, 1, 0, 0, 0, 0, 1, 0);
    addVec(0, 1, 1, 0, 0, 0, 0, 2, 0);
    addVec(0, 1, 1, 0, 0, 0, 0, 3, 0);
    addVec(0, 1, 1, 0, 0, 1, 4, 0, 0);
    addVec(0, 1, 2, 0, 0, 1, 4, 1, 0);
    addVec(0, 1, 2, 0, 0, 1, 4, 2, 0);
    addVec(0, 1, 2, 0, 0, 1, 4, 3, 0);
    addVec(0, 1, 2, 0, 0, 1, 4, 0, 0);
    addVec(0, 1, 3, 0, 0, 1, 4, 1, 0);
    addVec(0, 1, 3, 0, 0, 1, 4, 2, 0);
    addVec(0, 1, 3, 0, 0, 1, 4, 3, 0);
    addVec(0, 1, 3, 1, 0, 1, 8, 0, 0);
    addVec(0, 0, 0, 1, 0, 1, 12, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Push and pop together with a single entry held
    addVec(0, 1, 1, 0, 0, 0, 0, 1, 0);
    addVec(0, 1, 1, 0, 0, 0, 0, 2, 0);
    addVec(0, 1, 1, 0, 0, 0, 0, 3, 0);
    addVec(0, 1, 1, 0, 0, 1, 4, 0, 0);
    addVec(0, 1, 2, 0, 0, 1, 4, 1, 0);
    addVec(0, 1, 2, 0, 0, 1, 4, 2, 0);
    addVec(0, 1, 2, 0, 0, 1, 4, 3, 0);
    addVec(0, 1, 2, 1, 0, 1, 8, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Reset mid-frame leaves no residue
    addVec(0, 1, 2, 1, 0, 0, 0, 1, 0);
    addVec(0, 1, 2, 1, 0, 0, 0, 2, 0);
    addVec(1, 1, 3, 1, 0, 0, 0, 0, 0);
    addVec(0, 1, 2, 1, 0, 0, 0, 1, 0);
    addVec(0, 1, 2, 1, 0, 0, 0, 2, 0);
    addVec(0, 1, 2, 1, 0, 0, 0, 3, 0);
    addVec(0, 1, 2, 1, 0, 1, 8, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0);

    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].yv, vecs[i].y, vecs[i].rdy, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, int'(vecs[i].ed),
                  int'(vecs[i].eph), vecs[i].eovr);
    end

    // A drop on the same edge as ovr_clr keeps overrun set
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 4; s++) applyStimulus(0, 1, 3, 0, 0);
    for (int s = 0; s < 3; s++) applyStimulus(0, 1, 3, 0, 0);
    applyStimulus(0, 1, 3, 0, 1);
    checkOutput("set_wins", 1, 12, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_after", 1, 12, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_full", 0, 0, 0, 0);
    rst = 1'b0;

    // Narrow instance: 12 and 8 exceed 3 bits, 7 fits exactly
    n_rst = 1'b0;
    for (int s = 0; s < 4; s++) applyNarrow(1, 3);
    check("narrow12 valid", int'(n_out_valid), 1);
    check("narrow12 data", int'(n_data), EXP_SUM12);
    applyNarrow(1, 3); applyNarrow(1, 3); applyNarrow(1, 1); applyNarrow(1, 0);
    check("narrow7 data", int'(n_data), 7);
    applyNarrow(1, 3); applyNarrow(1, 3); applyNarrow(1, 2); applyNarrow(1, 0);
    check("narrow8 data", int'(n_data), EXP_SUM8);
    applyNarrow(0, 0);
    check("narrow drained", int'(n_out_valid), 0);
    check("narrow overrun", int'(n_ovr), 0);
    check("narrow phase", int'(n_phase), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
